id_ex_fwd_stage: RTL and testbench

//  ID/EX pipeline register plus forwarding/hazard control for the 5-stage MIPS core.

---
 rtl/id_ex_fwd_stage_pkg.sv | 39 +++
 rtl/id_ex_fwd_stage_if.sv | 50 +++++
 rtl/id_ex_fwd_stage_fwd_sel.sv | 29 ++
 rtl/id_ex_fwd_stage.sv | 91 +++++++++
 tb/tb_id_ex_fwd_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared MIPS pipeline definitions: widths, control-bundle bit positions,
// operand-mux select codes and the register-hit compare used by forwarding
// and hazard detection.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;

  // Bit positions inside the packed EX/MEM/WB control bundle
  localparam int CTRL_REGWR = 0;
  localparam int CTRL_MEMRD = 1;

  // Operand-mux selects, encoded as {sel2, sel1}
  localparam logic [1:0] FWD_REG = 2'b00;  // in1: latched register operand
  localparam logic [1:0] FWD_EXM = 2'b01;  // in2: EX/MEM result
  localparam logic [1:0] FWD_MWB = 2'b10;  // in3: MEM/WB result

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  // A writing stage supplies a usable value for src.
  // $0 is hard-wired to zero, so it never counts as a hit.
  function automatic logic rd_hit(input logic [REG_W-1:0] rd,
                                  input logic             wr,
                                  input logic [REG_W-1:0] src);
    return wr && (rd != {REG_W{1'b0}}) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_fwd_stage_if.sv
// Bundle of the ID-side inputs, the forwarding sources from EX/MEM and MEM/WB,
// and the EX-side outputs of the ID/EX stage.
interface id_ex_fwd_if;
  import mips_pkg::*;

  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic [REG_W-1:0]  exm_rd;
  logic              exm_wr;
  logic [REG_W-1:0]  mwb_rd;
  logic              mwb_wr;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              fwd_a_sel1;
  logic              fwd_a_sel2;
  logic              fwd_b_sel1;
  logic              fwd_b_sel2;
  logic              stall;

  // Upstream pipeline / environment side
  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_ctrl,
    output flush, exm_rd, exm_wr, mwb_rd, mwb_wr,
    input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
    input  fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2, stall
  );

  // ID/EX stage side
  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_ctrl,
    input  flush, exm_rd, exm_wr, mwb_rd, mwb_wr,
    output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
    output fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2, stall
  );

endinterface

// File: rtl/id_ex_fwd_stage_fwd_sel.sv
// Forwarding select for one ALU operand path. Pure combinational compare of
// the EX source register against the two later writing stages.
module fwd_sel
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] exm_rd,
  input  logic             exm_wr,
  input  logic [REG_W-1:0] mwb_rd,
  input  logic             mwb_wr,
  output logic [1:0]       sel
);

  // EX/MEM holds the newest value, so it is checked first; a bubble never forwards
  always_comb begin
    sel = FWD_REG;
    if (!ex_valid) begin
      sel = FWD_REG;
    end else if (rd_hit(exm_rd, exm_wr, src)) begin
      sel = FWD_EXM;
    end else if (rd_hit(mwb_rd, mwb_wr, src)) begin
      sel = FWD_MWB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with operand forwarding selects and load-use
// hazard detection for the 5-stage MIPS core.
module id_ex_fwd_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  id_ex_fwd_if.slave  bus
);

  ex_reg_t    ex_d;
  ex_reg_t    ex_q;
  logic       stall_s;
  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;

  // Load-use hazard: a load in EX writes a register the instruction in ID reads
  always_comb begin
    stall_s = 1'b0;
    if (ex_q.valid && ex_q.ctrl[CTRL_MEMRD] && bus.id_valid) begin
      stall_s = rd_hit(ex_q.rd, 1'b1, bus.id_rs) || rd_hit(ex_q.rd, 1'b1, bus.id_rt);
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next ID/EX contents: a bubble on flush or stall, otherwise the ID instruction
  always_comb begin
    ex_d         = '0;
    ex_d.rs_data = bus.id_rs_data;
    ex_d.rt_data = bus.id_rt_data;
    ex_d.imm     = bus.id_imm;
    ex_d.rs      = bus.id_rs;
    ex_d.rt      = bus.id_rt;
    ex_d.rd      = bus.id_rd;
    if (bus.flush || stall_s) begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = {CTRL_W{1'b0}};
    end else if (bus.id_valid) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = bus.id_ctrl;
    end else begin
      ex_d.valid = 1'b0;
      ex_d.ctrl  = {CTRL_W{1'b0}};
    end
  end

  // ID/EX register; reset empties EX so nothing is forwarded afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_sel u_fwd_a (
    .src      (ex_q.rs),
    .ex_valid (ex_q.valid),
    .exm_rd   (bus.exm_rd),
    .exm_wr   (bus.exm_wr),
    .mwb_rd   (bus.mwb_rd),
    .mwb_wr   (bus.mwb_wr),
    .sel      (sel_a_s)
  );

  fwd_sel u_fwd_b (
    .src      (ex_q.rt),
    .ex_valid (ex_q.valid),
    .exm_rd   (bus.exm_rd),
    .exm_wr   (bus.exm_wr),
    .mwb_rd   (bus.mwb_rd),
    .mwb_wr   (bus.mwb_wr),
    .sel      (sel_b_s)
  );

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_rs_data = ex_q.rs_data;
  assign bus.ex_rt_data = ex_q.rt_data;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.fwd_a_sel1 = sel_a_s[0];
  assign bus.fwd_a_sel2 = sel_a_s[1];
  assign bus.fwd_b_sel1 = sel_b_s[0];
  assign bus.fwd_b_sel2 = sel_b_s[1];
  assign bus.stall      = stall_s;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Self-checking bench for id_ex_fwd_stage: directed scenarios followed by
// randomized traffic, all compared against a reference model of the stage.
module tb_id_ex_fwd_stage;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  id_ex_fwd_if b ();

  id_ex_fwd_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of what EX currently holds
  logic              m_valid;
  logic [DATA_W-1:0] m_rs_data, m_rt_data, m_imm;
  logic [REG_W-1:0]  m_rs, m_rt, m_rd;
  logic [CTRL_W-1:0] m_ctrl;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which stage the operand for register src should come from
  function automatic int exp_fwd(input logic [REG_W-1:0] src);
    if (!m_valid || src == 0) return 0;
    if (b.exm_wr && b.exm_rd == src) return 1;
    if (b.mwb_wr && b.mwb_rd == src) return 2;
    return 0;
  endfunction

  function automatic int exp_stall();
    if (!(m_valid && m_ctrl[1] && b.id_valid) || m_rd == 0) return 0;
    return ((m_rd == b.id_rs) || (m_rd == b.id_rt)) ? 1 : 0;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
  endtask

  task automatic check_comb();
    #1;
    check_val("fwd_a", 32'({b.fwd_a_sel2, b.fwd_a_sel1}), 32'(exp_fwd(m_rs)));
    check_val("fwd_b", 32'({b.fwd_b_sel2, b.fwd_b_sel1}), 32'(exp_fwd(m_rt)));
    check_val("stall", 32'(b.stall), 32'(exp_stall()));
  endtask

  task automatic check_regs();
    check_val("ex_valid", 32'(b.ex_valid), 32'(m_valid));
    check_val("ex_ctrl", 32'(b.ex_ctrl), 32'(m_ctrl));
    check_val("ex_rs_data", b.ex_rs_data, m_rs_data);
    check_val("ex_rt_data", b.ex_rt_data, m_rt_data);
    check_val("ex_imm", b.ex_imm, m_imm);
    check_val("ex_regs", 32'({b.ex_rs, b.ex_rt, b.ex_rd}), 32'({m_rs, m_rt, m_rd}));
  endtask

  // Check combinational outputs, advance one clock, update the model, check registers
  task automatic tick();
    int bubble;
    check_comb();
    bubble = (b.flush || exp_stall() != 0) ? 1 : 0;
    m_rs_data = b.id_rs_data; m_rt_data = b.id_rt_data; m_imm = b.id_imm;
    m_rs = b.id_rs; m_rt = b.id_rt; m_rd = b.id_rd;
    if (bubble != 0 || !b.id_valid) begin
      m_valid = 1'b0; m_ctrl = '0;
    end else begin
      m_valid = 1'b1; m_ctrl = b.id_ctrl;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_id(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic [REG_W-1:0] rd, input logic [CTRL_W-1:0] ctrl);
    b.id_valid = v; b.id_rs = rs; b.id_rt = rt; b.id_rd = rd; b.id_ctrl = ctrl;
    b.id_rs_data = $urandom; b.id_rt_data = $urandom; b.id_imm = $urandom;
  endtask

  task automatic set_fwd(input logic [REG_W-1:0] erd, input logic ewr,
                         input logic [REG_W-1:0] mrd, input logic mwr);
    b.exm_rd = erd; b.exm_wr = ewr; b.mwb_rd = mrd; b.mwb_wr = mwr;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    reset = 1'b1;
    b.flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00);
    set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
    #12;
    check_regs();
    reset = 1'b0;

    // Forwarding into an add with rs=3, rt=5
    set_id(1'b1, 5'd3, 5'd5, 5'd7, 8'h01);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00);
    set_fwd(5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    check_val("a_exm", 32'({b.fwd_a_sel2, b.fwd_a_sel1}), 32'd1);
    set_fwd(5'd0, 1'b0, 5'd3, 1'b1);
    #1;
    check_val("a_mwb", 32'({b.fwd_a_sel2, b.fwd_a_sel1}), 32'd2);
    set_fwd(5'd5, 1'b1, 5'd5, 1'b1);
    #1;
    check_val("b_prio", 32'({b.fwd_b_sel2, b.fwd_b_sel1}), 32'd1);

    // $0 source is never forwarded
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 8'h01);
    tick();
    set_fwd(5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check_val("zero_reg", 32'({b.fwd_a_sel2, b.fwd_a_sel1}), 32'd0);

    // Load-use: lw r8, then add using r8
    set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
    set_id(1'b1, 5'd1, 5'd8, 5'd8, 8'h03);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 5'd9, 8'h01);
    #1;
    check_val("lu_stall", 32'(b.stall), 32'd1);
    tick();
    check_val("lu_bubble", 32'(b.ex_valid), 32'd0);
    check_val("lu_stall_gone", 32'(b.stall), 32'd0);
    set_fwd(5'd8, 1'b1, 5'd0, 1'b0);
    tick();
    check_val("lu_add_a", 32'({b.fwd_a_sel2, b.fwd_a_sel1}), 32'd1);

    // Flush squashes a valid instruction with all control bits set
    b.flush = 1'b1;
    set_id(1'b1, 5'd4, 5'd6, 5'd10, 8'hFF);
    tick();
    check_val("flush_valid", 32'(b.ex_valid), 32'd0);
    check_val("flush_ctrl", 32'(b.ex_ctrl), 32'd0);
    b.flush = 1'b0;

    // Asynchronous reset while EX holds a load that would forward and stall
    set_id(1'b1, 5'd11, 5'd12, 5'd13, 8'h03);
    tick();
    set_fwd(5'd11, 1'b1, 5'd12, 1'b1);
    set_id(1'b1, 5'd13, 5'd0, 5'd1, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_val("rst_valid", 32'(b.ex_valid), 32'd0);
    check_val("rst_ctrl", 32'(b.ex_ctrl), 32'd0);
    check_val("rst_sel", 32'({b.fwd_a_sel2, b.fwd_a_sel1, b.fwd_b_sel2, b.fwd_b_sel1}), 32'd0);
    check_val("rst_stall", 32'(b.stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic over a small register range to provoke hits
    for (int i = 0; i < 300; i++) begin
      set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 8'($urandom));
      b.flush = ($urandom_range(0, 7) == 0);
      set_fwd(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
